// File: rtl/izh_syn_pkg.sv
// izh_syn_pkg: shared types, widths and saturating arithmetic for the synapse receiver
package izh_syn_pkg;
   localparam int I_W = 5;
   typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} syn_state_e;
   function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                           input int unsigned max);
      return (a + b > max) ? max : a + b;
   endfunction
   function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
      return (a > b) ? a - b : 0;
   endfunction
endpackage

// File: rtl/syn_rate_window.sv
// syn_rate_window: counts spike events over fixed windows of enabled cycles
//   clk, rst (async, active-high), enable (0 freezes), ev (one-cycle event)
//   rate_count: events in last completed window (saturating)
//   rate_valid: one-cycle pulse coinciding with each rate_count update
module syn_rate_window
   import izh_syn_pkg::*;
#(
   parameter int WIN_LEN = 1024,
   parameter int CNT_W   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             ev,
   output logic [CNT_W-1:0] rate_count,
   output logic             rate_valid
);
   localparam int WW = $clog2(WIN_LEN);
   localparam int unsigned CNT_MAX = 2**CNT_W - 1;
   logic [WW-1:0]    win_q, win_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, rc_q, rc_d;
   logic             rv_q, rv_d, last;
   always_comb begin
      last    = enable && win_q == WW'(WIN_LEN - 1);
      cnt_inc = CNT_W'(sat_add(32'(cnt_q), 32'(ev), CNT_MAX));
      win_d   = !enable ? win_q : last ? '0 : win_q + WW'(1);
      // the event landing on the final cycle still belongs to the closing window
      cnt_d   = !enable ? cnt_q : last ? '0 : cnt_inc;
      rc_d    = last ? cnt_inc : rc_q;
      rv_d    = last;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         win_q <= '0;
         cnt_q <= '0;
         rc_q  <= '0;
         rv_q  <= 1'b0;
      end else begin
         win_q <= win_d;
         cnt_q <= cnt_d;
         rc_q  <= rc_d;
         rv_q  <= rv_d;
      end
   assign rate_count = rc_q;
   assign rate_valid = rv_q;
endmodule

// File: rtl/izh_synapse_rx.sv
// izh_synapse_rx: turns upstream spikes into a decaying weighted current for a neuron
//   clk, rst (async, active-high), enable (0 = hold all state)
//   spike_in (level), weight (5b, sampled on event), inhibit (1 = subtract)
//   I_out: top 5 bits of accumulator; syn_active: accumulator nonzero
//   rate_count / rate_valid: per-window event count and its update strobe
module izh_synapse_rx
   import izh_syn_pkg::*;
#(
   parameter int ACC_W       = 8,
   parameter int DECAY_DIV   = 16,
   parameter int DECAY_SHIFT = 3,
   parameter int WIN_LEN     = 1024,
   parameter int CNT_W       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             spike_in,
   input  logic [I_W-1:0]   weight,
   input  logic             inhibit,
   output logic [I_W-1:0]   I_out,
   output logic             syn_active,
   output logic [CNT_W-1:0] rate_count,
   output logic             rate_valid
);
   localparam int PW = $clog2(DECAY_DIV);
   localparam int unsigned ACC_MAX = 2**ACC_W - 1;
   syn_state_e       state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [ACC_W-1:0] acc_q, acc_d, ws, dec, base, shr;
   logic             spk_q, spk_d, ev, run, tick;
   always_comb begin
      spk_d   = spike_in;
      ev      = spike_in & ~spk_q & enable;
      // state_q is ACTIVE only after a full enabled cycle with nonzero acc
      run     = enable && state_q == ACTIVE;
      tick    = run && presc_q == PW'(DECAY_DIV - 1);
      ws      = ACC_W'(weight) << (ACC_W - I_W);
      shr     = acc_q >> DECAY_SHIFT;
      dec     = !tick ? '0 : shr == '0 ? ACC_W'(1) : shr;
      base    = acc_q - dec;
      acc_d   = !enable ? acc_q : !ev ? base :
                inhibit ? ACC_W'(sat_sub(32'(base), 32'(ws))) :
                          ACC_W'(sat_add(32'(base), 32'(ws), ACC_MAX));
      presc_d = !enable ? presc_q : acc_d == '0 ? '0 : !run ? presc_q :
                tick ? '0 : presc_q + PW'(1);
      state_d = !enable ? HOLD : acc_d != '0 ? ACTIVE : IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         acc_q   <= '0;
         spk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         acc_q   <= acc_d;
         spk_q   <= spk_d;
      end
   assign I_out      = acc_q[ACC_W-1 -: I_W];
   assign syn_active = acc_q != '0;
   syn_rate_window #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) u_rate (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .ev         (ev),
      .rate_count (rate_count),
      .rate_valid (rate_valid)
   );
endmodule
